mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single burst physical-memory port between the I-cache (read-only) and the D-cache (read/write) of the pipelined RV32I core.
//  Sits between both cache miss interfaces and pmem. Each transaction moves one cache line as a fixed-length burst.
//  Serializes D-cache write-back lines into beats and assembles read beats into lines. Round-robin on contention.
// PARAMETERS
//  ADDR_WIDTH  32   byte address width
//  LINE_WIDTH  256  cache line bits
//  BEAT_WIDTH  64   pmem data bits per beat; BURST_LEN = LINE_WIDTH/BEAT_WIDTH (4)
// PORTS
//  clk            in   1    single clock; all state on rising edge
//  rst_n          in   1    asynchronous, active-low reset
//  i_read         in   1    I-cache line read request, held until i_resp
//  i_address      in   32   I-cache line address
//  i_rdata        out  256  line returned to I-cache
//  i_resp         out  1    I-cache transaction done (1-cycle pulse)
//  d_read         in   1    D-cache line read request, held until d_resp
//  d_write        in   1    D-cache line write-back request, held until d_resp
//  d_address      in   32   D-cache line address
//  d_wdata        in   256  write-back line
//  d_rdata        out  256  line returned to D-cache
//  d_resp         out  1    D-cache transaction done (1-cycle pulse)
//  pmem_read      out  1    burst read active
//  pmem_write     out  1    burst write active
//  pmem_address   out  32   line-aligned burst address
//  pmem_wdata     out  64   current write beat
//  pmem_rdata     in   64   current read beat
//  pmem_resp      in   1    beat accepted/valid this cycle
// BEHAVIOUR
//  - Reset: state=IDLE, beat_cnt=0, line buffer=0, last_grant=ICACHE.
//    All outputs 0 (pmem_read/write/resp lines, addr, wdata, rdata).
//  - FSM: IDLE -> {I_RD, D_RD, D_WR} -> DONE -> IDLE.
//  - IDLE: sample requests.
//    - One requester active: grant it.
//    - Both active: grant the one not equal to last_grant.
//    - Latch the granted address as {addr[31:5],5'b0}.
//    - On a D_WR grant, latch d_wdata into the line buffer; clear beat_cnt.
//  - d_read&d_write both high: treated as D_WR (write takes priority; not a legal cache state).
//  - Latency: pmem_read/pmem_write assert the cycle after the IDLE grant cycle.
//    They hold steady through the whole burst and drop the cycle after the final beat's pmem_resp.
//  - pmem_address is constant for the whole burst. The memory side sequences beats.
//  - Beat k, k=0..BURST_LEN-1, is line[BEAT_WIDTH*k +: BEAT_WIDTH]. Beat 0 goes first.
//  - Read: on each pmem_resp, store pmem_rdata into slot beat_cnt; beat_cnt++.
//  - Write: pmem_wdata = slot beat_cnt; advance on pmem_resp.
//  - Cycles without pmem_resp stall the burst. No timeout.
//  - beat_cnt==BURST_LEN-1 && pmem_resp: go to DONE; beat_cnt wraps to 0.
//  - DONE (1 cycle):
//    - Pulse i_resp or d_resp for the granted requester only.
//    - The matching *_rdata is valid that cycle and held until the next read of the same requester completes.
//    - Set last_grant=granted requester. pmem_read/write = 0.
//  - Requests are not sampled in DONE. A requester deasserts the cycle after its resp.
//    A still-pending other requester is granted in the following IDLE cycle.
//  - pmem_resp in IDLE/DONE: ignored.
//  - Request dropped mid-burst: the burst still completes and resp is still pulsed. Grants are non-preemptive.
//  - rst_n low mid-burst: immediate return to reset values. The partial line is discarded.
// STRUCTURE
//  - Shared package rv32i_types gains: arb_state_t enum {IDLE,I_RD,D_RD,D_WR,DONE}; arb_grant_t {ICACHE,DCACHE}; LINE_WIDTH/BEAT_WIDTH constants.
//  - Sub-module arbiter_line_buffer: line register, beat counter, per-beat write/select, last-beat flag.
//  - Top holds the FSM, grant/round-robin logic and output decode.
// TESTING
//  1. Lone I-read @0x0000_1234:
//     - pmem_address=0x0000_1220.
//     - Beats 0x11..,0x22..,0x33..,0x44.. with resp every cycle.
//     - i_rdata={beat3,beat2,beat1,beat0}; i_resp 1 cycle; d_resp stays 0.
//  2. Lone D-write @0x8000_0040, d_wdata=256'hA..D, pmem_resp every other cycle:
//     - 4 beats in order, pmem_wdata = wdata[63:0] first.
//     - pmem_write held 8 cycles; single d_resp.
//  3. i_read & d_read raised in the same cycle after reset:
//     - D served first (last_grant=ICACHE), then I.
//     - Repeat the contention: order alternates I, then D.
//  4. d_read & d_write both high: write burst issued; no read burst.
//  5. rst_n low after beat 2 of an I-read:
//     - All outputs 0 asynchronously; no i_resp.
//     - The next request restarts from beat 0.
//  6. pmem_resp pulsed while IDLE with no request: no state change, no resp outputs.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared types and line/beat geometry for the memory port arbiter
//   ADDR_WIDTH/LINE_WIDTH/BEAT_WIDTH/BURST_LEN : default byte-address, line and beat sizes
//   arb_state_t : IDLE, I_RD, D_RD, D_WR, DONE
//   arb_grant_t : ICACHE, DCACHE
//   offset_bits : number of byte-offset bits inside one line
package mem_port_arbiter_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int LINE_WIDTH = 256;
  localparam int BEAT_WIDTH = 64;
  localparam int BURST_LEN  = LINE_WIDTH / BEAT_WIDTH;
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    I_RD = 3'd1,
    D_RD = 3'd2,
    D_WR = 3'd3,
    DONE = 3'd4
  } arb_state_t;
  typedef enum logic {
    ICACHE = 1'b0,
    DCACHE = 1'b1
  } arb_grant_t;
  function automatic int offset_bits(input int line_bits);
    return $clog2(line_bits / 8);
  endfunction
endpackage

// File: rtl/mem_port_arbiter_line_buffer.sv
// arbiter_line_buffer: one cache line split into beats, with the beat counter of the current burst
//   clk, rst_n : clock, asynchronous active-low reset
//   i_load     : capture i_line whole (write-back line)
//   i_clr      : restart the beat counter at beat 0
//   i_adv      : current beat accepted, move to the next one (wraps after the last)
//   i_store    : write i_beat into the current slot
//   i_line     : full line to load
//   i_beat     : incoming read beat
//   o_line     : line including a beat being stored this cycle
//   o_beat     : slot selected by the beat counter
//   o_last     : beat counter is on the final beat
module arbiter_line_buffer #(
  parameter int LINE_WIDTH = 256,
  parameter int BEAT_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_load,
  input  logic                  i_clr,
  input  logic                  i_adv,
  input  logic                  i_store,
  input  logic [LINE_WIDTH-1:0] i_line,
  input  logic [BEAT_WIDTH-1:0] i_beat,
  output logic [LINE_WIDTH-1:0] o_line,
  output logic [BEAT_WIDTH-1:0] o_beat,
  output logic                  o_last
);
  localparam int BURST_LEN = LINE_WIDTH / BEAT_WIDTH;
  localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  logic [CW-1:0]         r_cnt;
  logic [LINE_WIDTH-1:0] r_line;
  logic [LINE_WIDTH-1:0] w_merged;
  always_comb begin
    w_merged = r_line;
    w_merged[int'(r_cnt)*BEAT_WIDTH +: BEAT_WIDTH] = i_beat;
  end
  // Exposing the merged line lets the owner capture a complete line on the final beat.
  assign o_line = i_store ? w_merged : r_line;
  assign o_beat = r_line[int'(r_cnt)*BEAT_WIDTH +: BEAT_WIDTH];
  assign o_last = r_cnt == CW'(BURST_LEN - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_line <= '0;
      r_cnt  <= '0;
    end else begin
      r_line <= i_load ? i_line : i_store ? w_merged : r_line;
      r_cnt  <= i_clr ? '0 : !i_adv ? r_cnt : o_last ? '0 : r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one burst pmem port between I-cache reads and D-cache reads/write-backs
//   clk, rst_n              : clock, asynchronous active-low reset
//   i_read, i_address       : I-cache line read request (held until i_resp)
//   i_rdata, i_resp         : I-cache returned line, one-cycle completion pulse
//   d_read, d_write         : D-cache line read / write-back request (held until d_resp)
//   d_address, d_wdata      : D-cache line address, write-back line
//   d_rdata, d_resp         : D-cache returned line, one-cycle completion pulse
//   pmem_read, pmem_write   : burst active (read / write)
//   pmem_address            : line-aligned burst address
//   pmem_wdata, pmem_rdata  : outgoing / incoming beat
//   pmem_resp               : beat accepted or valid this cycle
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = mem_port_arbiter_pkg::ADDR_WIDTH,
  parameter int LINE_WIDTH = mem_port_arbiter_pkg::LINE_WIDTH,
  parameter int BEAT_WIDTH = mem_port_arbiter_pkg::BEAT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [BEAT_WIDTH-1:0] pmem_wdata,
  input  logic [BEAT_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);
  import mem_port_arbiter_pkg::*;
  localparam int OFF = offset_bits(LINE_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ALIGN = {{(ADDR_WIDTH-OFF){1'b1}}, {OFF{1'b0}}};
  arb_state_t            r_state;
  arb_state_t            w_state_next;
  arb_grant_t            r_grant;
  arb_grant_t            r_last_grant;
  arb_grant_t            w_pick;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LINE_WIDTH-1:0] r_i_rdata;
  logic [LINE_WIDTH-1:0] r_d_rdata;
  logic [LINE_WIDTH-1:0] w_line;
  logic [BEAT_WIDTH-1:0] w_beat;
  logic                  w_i_req;
  logic                  w_d_req;
  logic                  w_grant;
  logic                  w_rd_burst;
  logic                  w_burst;
  logic                  w_last;
  logic                  w_final;
  always_comb begin
    w_i_req      = i_read;
    w_d_req      = d_read | d_write;
    // Round-robin: under contention the requester not served last wins.
    w_pick       = (w_d_req && (!w_i_req || r_last_grant == ICACHE)) ? DCACHE : ICACHE;
    w_grant      = (r_state == IDLE) && (w_i_req || w_d_req);
    w_rd_burst   = (r_state == I_RD) || (r_state == D_RD);
    w_burst      = w_rd_burst || (r_state == D_WR);
    w_final      = w_burst && pmem_resp && w_last;
    // d_write wins over d_read when both are raised.
    w_state_next = w_grant ? (w_pick == ICACHE ? I_RD : d_write ? D_WR : D_RD)
                 : (r_state == DONE) ? IDLE
                 : w_final ? DONE
                 : r_state;
  end
  arbiter_line_buffer #(
    .LINE_WIDTH(LINE_WIDTH),
    .BEAT_WIDTH(BEAT_WIDTH)
  ) u_line_buffer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_grant && w_pick == DCACHE && d_write),
    .i_clr   (w_grant),
    .i_adv   (w_burst && pmem_resp),
    .i_store (w_rd_burst && pmem_resp),
    .i_line  (d_wdata),
    .i_beat  (pmem_rdata),
    .o_line  (w_line),
    .o_beat  (w_beat),
    .o_last  (w_last)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_grant      <= ICACHE;
      r_last_grant <= ICACHE;
      r_addr       <= '0;
      r_i_rdata    <= '0;
      r_d_rdata    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_grant) begin
        r_grant <= w_pick;
        r_addr  <= (w_pick == ICACHE ? i_address : d_address) & ALIGN;
      end
      if (r_state == DONE) r_last_grant <= r_grant;
      // Per-requester copies keep each returned line stable across the other's traffic.
      if (w_final && r_state == I_RD) r_i_rdata <= w_line;
      if (w_final && r_state == D_RD) r_d_rdata <= w_line;
    end
  end
  assign pmem_read    = w_rd_burst;
  assign pmem_write   = r_state == D_WR;
  assign pmem_address = r_addr;
  assign pmem_wdata   = pmem_write ? w_beat : '0;
  assign i_resp       = (r_state == DONE) && (r_grant == ICACHE);
  assign d_resp       = (r_state == DONE) && (r_grant == DCACHE);
  assign i_rdata      = r_i_rdata;
  assign d_rdata      = r_d_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: random cache traffic against a transaction-level memory and round-robin model
module tb_mem_port_arbiter;
  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         i_read = 1'b0, d_read = 1'b0, d_write = 1'b0, pmem_resp = 1'b0;
  logic [31:0]  i_address = '0, d_address = '0;
  logic [255:0] d_wdata = '0;
  logic [63:0]  pmem_rdata = '0;
  logic         i_resp, d_resp, pmem_read, pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] i_rdata, d_rdata;
  logic [63:0]  pmem_wdata;

  mem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [255:0] mem [logic [31:0]];
  bit act = 0, b_who = 0, b_wr = 0, lg = 0, i_busy = 0, d_busy = 0;
  bit auto_en = 0, noise = 0, alt = 0, alt_ph = 0, pend_wr = 0;
  int pend = 0, b_beat = 0, resp_pct = 60, i_wait = 0, d_wait = 0, wcyc = 0;
  logic [31:0]  b_addr = '0, pend_addr = '0;
  logic [255:0] b_line = '0, pend_line = '0, last_i = '0, last_d = '0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] line_of(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a, 32'h4, a, 32'h3, a, 32'h2, ~a, 32'h1};
  endfunction

  function automatic logic [31:0] rand_addr();
    return 32'($urandom_range(511)) | ($urandom_range(1) == 1 ? 32'h8000_0000 : 32'h0);
  endfunction

  task automatic cycle();
    bit act_now, go;
    int r;
    @(posedge clk); #1;
    act_now = pmem_read | pmem_write;
    if (pmem_write) wcyc++;
    // Requests seen here are exactly the ones the arbiter sampled at this edge.
    if (act_now && !act && pend == 0 && (i_read || d_read || d_write)) begin
      b_who  = (i_read && (d_read || d_write)) ? !lg : (d_read || d_write);
      b_wr   = b_who && d_write;
      b_addr = (b_who ? d_address : i_address) & ~32'h1f;
      b_line = b_wr ? d_wdata : line_of(b_addr);
      b_beat = 0;
      act    = 1;
      check("start_write", pmem_write, b_wr);
      check("start_read", pmem_read, !b_wr);
      check("start_addr", pmem_address, b_addr);
    end else if (act) begin
      check("burst_hold", {pmem_read, pmem_write, pmem_address}, {!b_wr, b_wr, b_addr});
    end else if (pend == 0) begin
      check("idle_quiet", {act_now, i_resp, d_resp}, 3'b000);
    end
    if (pend != 0) begin
      check("resp", {act_now, i_resp, d_resp}, {1'b0, pend == 1, pend == 2});
      if (pend == 1) begin
        check("i_rdata", i_rdata, pend_line);
        last_i = pend_line; i_read = 0; i_busy = 0; lg = 0;
      end else begin
        if (pend_wr) mem[pend_addr] = pend_line;
        else begin
          check("d_rdata", d_rdata, pend_line);
          last_d = pend_line;
        end
        d_read = 0; d_write = 0; d_busy = 0; lg = 1;
      end
      pend = 0;
    end else begin
      check("i_hold", i_rdata, last_i);
      check("d_hold", d_rdata, last_d);
    end
    pmem_rdata = {$urandom, $urandom};
    if (act) begin
      if (alt) begin
        go = alt_ph;
        alt_ph = !alt_ph;
      end else go = $urandom_range(99) < resp_pct;
      pmem_resp = go;
      if (go) begin
        if (b_wr) check("pmem_wdata", pmem_wdata, b_line[b_beat*64 +: 64]);
        else pmem_rdata = b_line[b_beat*64 +: 64];
        b_beat++;
        if (b_beat == 4) begin
          act = 0; pend = b_who ? 2 : 1; pend_line = b_line; pend_wr = b_wr; pend_addr = b_addr;
        end
      end
    end else pmem_resp = noise && $urandom_range(2) == 0;
    if (i_busy) begin
      i_wait++;
      if (i_wait > 400) begin check("i_timeout", i_resp, 1'b1); i_busy = 0; i_read = 0; end
    end
    if (d_busy) begin
      d_wait++;
      if (d_wait > 400) begin check("d_timeout", d_resp, 1'b1); d_busy = 0; d_read = 0; d_write = 0; end
    end
    if (auto_en && !i_busy && pend == 0 && $urandom_range(2) == 0) begin
      i_busy = 1; i_wait = 0; i_read = 1; i_address = rand_addr();
    end
    if (auto_en && !d_busy && pend == 0 && $urandom_range(2) == 0) begin
      r = $urandom_range(9);
      d_busy = 1; d_wait = 0; d_write = (r < 4) || (r == 9); d_read = r >= 4; d_address = rand_addr();
      for (int k = 0; k < 8; k++) d_wdata[k*32 +: 32] = $urandom;
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 1000 && (i_busy || d_busy || act || pend != 0); n++) cycle();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, {pmem_read, pmem_write, i_resp, d_resp}, 4'b0);
    check({tag, "_addr"}, pmem_address, 32'h0);
    check({tag, "_wdata"}, pmem_wdata, 64'h0);
    check({tag, "_i_rdata"}, i_rdata, 256'h0);
    check({tag, "_d_rdata"}, d_rdata, 256'h0);
  endtask

  initial begin
    #1 rst_n = 0;
    #2 check_zero("reset");
    @(negedge clk) rst_n = 1;
    // Simultaneous requests right after reset: D first, then I.
    i_busy = 1; d_busy = 1; i_read = 1; d_read = 1;
    i_address = 32'h0000_1234; d_address = 32'h8000_0040;
    drain();
    check("i_line_0x1220", i_rdata, line_of(32'h0000_1220));
    // Lone write-back with a response every other cycle.
    alt = 1; alt_ph = 0; wcyc = 0;
    d_busy = 1; d_wait = 0; d_write = 1; d_address = 32'h8000_0040;
    d_wdata = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC, 64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    drain();
    alt = 0;
    check("wr_cycles", 256'(wcyc), 256'd8);
    // Read and write raised together behave as a write-back.
    d_busy = 1; d_wait = 0; d_read = 1; d_write = 1; d_address = 32'h0000_0100;
    d_wdata = {4{64'h0123_4567_89AB_CDEF}};
    drain();
    // Random mixed traffic.
    auto_en = 1;
    repeat (3000) cycle();
    auto_en = 0;
    drain();
    // Stray beat responses while idle.
    noise = 1;
    repeat (20) cycle();
    noise = 0;
    // Reset in the middle of an I-cache burst, then a clean retry.
    resp_pct = 100;
    i_busy = 1; i_wait = 0; i_read = 1; i_address = 32'h0000_1234;
    for (int n = 0; n < 20 && !(act && b_beat >= 2); n++) cycle();
    @(posedge clk); #3;
    rst_n = 0;
    #1 check_zero("midreset");
    act = 0; pend = 0; lg = 0; last_i = '0; last_d = '0; pmem_resp = 0; i_wait = 0;
    @(negedge clk) rst_n = 1;
    drain();
    check("retry_line", i_rdata, line_of(32'h0000_1220));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
